// File: rtl/spi_fifo_pkg.sv
// Shared types for the SPI FIFO bridge: byte width and the TX/RX handshake state encodings.
package spi_fifo_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_GUARD = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ACK   = 2'd1,
    RX_GUARD = 2'd2
  } rx_state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// Circular byte FIFO with first-word-fall-through output and registered full/empty/count.
module spi_byte_fifo
  import spi_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              sysclk,
  input  logic              nreset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  localparam int AW = CW - 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge sysclk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/spi_fifo_bridge.sv
// TX/RX byte FIFOs between the host registers and the spi_master single-byte handshake.
module spi_fifo_bridge
  import spi_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              sysclk,
  input  logic              nreset,
  input  logic [BYTE_W-1:0] host_wdata,
  input  logic              host_we,
  input  logic              host_re,
  output logic [BYTE_W-1:0] host_rdata,
  input  logic              flush,
  input  logic              clear_flags,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              rx_full,
  output logic              rx_empty,
  output logic [CW-1:0]     tx_count,
  output logic [CW-1:0]     rx_count,
  output logic              tx_ovf,
  output logic              rx_udf,
  output logic [BYTE_W-1:0] tx_data_reg,
  output logic              tx_reg_we,
  input  logic              tx_reg_empty,
  input  logic [BYTE_W-1:0] rx_data_reg,
  input  logic              rx_data_ready,
  output logic              rx_reg_re
);
  logic              tx_pop;
  logic              rx_push;
  logic [BYTE_W-1:0] tx_dout;
  logic [BYTE_W-1:0] rx_dout;
  logic [BYTE_W-1:0] rdata_last;
  tx_state_t         tx_state, tx_state_nxt;
  rx_state_t         rx_state, rx_state_nxt;

  spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .sysclk(sysclk), .nreset(nreset), .push(host_we), .pop(tx_pop), .flush(flush),
    .din(host_wdata), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .sysclk(sysclk), .nreset(nreset), .push(rx_push), .pop(host_re), .flush(flush),
    .din(rx_data_reg), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // A flush wins over a handshake transfer, so the byte is neither lost nor sent.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_reg_empty && !tx_empty && !flush) begin
          tx_state_nxt = TX_LOAD;
          tx_pop       = 1'b1;
        end
      end
      TX_LOAD:  tx_state_nxt = TX_GUARD;
      TX_GUARD: tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_data_ready && !rx_full && !flush) begin
          rx_state_nxt = RX_ACK;
          rx_push      = 1'b1;
        end
      end
      RX_ACK:   rx_state_nxt = RX_GUARD;
      RX_GUARD: rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      tx_state    <= TX_IDLE;
      rx_state    <= RX_IDLE;
      tx_reg_we   <= 1'b0;
      rx_reg_re   <= 1'b0;
      tx_data_reg <= '0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
      rdata_last  <= '0;
    end else begin
      tx_state  <= tx_state_nxt;
      rx_state  <= rx_state_nxt;
      tx_reg_we <= tx_pop;
      rx_reg_re <= rx_push;
      if (tx_pop) tx_data_reg <= tx_dout;
      if (clear_flags)             tx_ovf <= 1'b0;
      else if (host_we && tx_full) tx_ovf <= 1'b1;
      if (clear_flags)              rx_udf <= 1'b0;
      else if (host_re && rx_empty) rx_udf <= 1'b1;
      if (!rx_empty) rdata_last <= rx_dout;
    end
  end

  // Once the RX FIFO runs dry the last head seen by the host stays on the bus.
  assign host_rdata = rx_empty ? rdata_last : rx_dout;
endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Bench for spi_fifo_bridge: queue-based reference model plus a behavioural spi_master stand-in.
module tb_spi_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          sysclk = 1'b0;
  logic          nreset;
  logic [7:0]    host_wdata;
  logic          host_we;
  logic          host_re;
  logic [7:0]    host_rdata;
  logic          flush;
  logic          clear_flags;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_udf;
  logic [7:0]    tx_data_reg;
  logic          tx_reg_we;
  logic          tx_reg_empty;
  logic [7:0]    rx_data_reg;
  logic          rx_data_ready;
  logic          rx_reg_re;

  spi_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .nreset(nreset), .host_wdata(host_wdata), .host_we(host_we),
    .host_re(host_re), .host_rdata(host_rdata), .flush(flush), .clear_flags(clear_flags),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_count(tx_count), .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_udf(rx_udf),
    .tx_data_reg(tx_data_reg), .tx_reg_we(tx_reg_we), .tx_reg_empty(tx_reg_empty),
    .rx_data_reg(rx_data_reg), .rx_data_ready(rx_data_ready), .rx_reg_re(rx_reg_re)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] tx_hold, last_rd;
  bit         ovf_m, udf_m;
  int         tx_busy, rx_busy;

  // spi_master stand-in state
  bit         spi_auto, loopback;
  int         frame_cnt, frame_len;
  logic [7:0] spi_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    txq.delete();
    rxq.delete();
    tx_hold = 8'h00; last_rd = 8'h00;
    ovf_m = 0; udf_m = 0;
    tx_busy = 0; rx_busy = 0;
    frame_cnt = 0; tx_reg_empty = 1'b1; rx_data_ready = 1'b0;
  endtask

  task automatic step();
    int         tx_pre, rx_pre;
    bit         exp_we, exp_re;
    logic       we_pre, re_pre;
    logic [7:0] data_pre, rd_exp;
    tx_pre = txq.size();
    rx_pre = rxq.size();
    exp_we = 0;
    exp_re = 0;
    we_pre = tx_reg_we; re_pre = rx_reg_re; data_pre = tx_data_reg;
    // After a transfer the engine needs two more cycles before it can take another.
    if (tx_busy > 0) tx_busy--;
    else if (tx_reg_empty && tx_pre > 0 && !flush) begin exp_we = 1; tx_busy = 2; end
    if (rx_busy > 0) rx_busy--;
    else if (rx_data_ready && rx_pre < DEPTH && !flush) begin exp_re = 1; rx_busy = 2; end
    if (exp_we) tx_hold = txq[0];
    if (flush) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (exp_we) void'(txq.pop_front());
      if (host_we && tx_pre < DEPTH) txq.push_back(host_wdata);
      if (host_re && rx_pre > 0) void'(rxq.pop_front());
      if (exp_re) rxq.push_back(rx_data_reg);
    end
    if (clear_flags) ovf_m = 0; else if (host_we && tx_pre == DEPTH) ovf_m = 1;
    if (clear_flags) udf_m = 0; else if (host_re && rx_pre == 0) udf_m = 1;

    @(posedge sysclk); #1;

    if (re_pre) rx_data_ready = 1'b0;
    if (spi_auto) begin
      if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin
          tx_reg_empty = 1'b1;
          if (loopback) begin rx_data_reg = spi_byte; rx_data_ready = 1'b1; end
        end
      end
      if (we_pre) begin spi_byte = data_pre; tx_reg_empty = 1'b0; frame_cnt = frame_len; end
    end

    rd_exp  = (rxq.size() > 0) ? rxq[0] : last_rd;
    last_rd = rd_exp;
    check("tx_reg_we",   tx_reg_we,   exp_we);
    check("rx_reg_re",   rx_reg_re,   exp_re);
    check("tx_data_reg", tx_data_reg, tx_hold);
    check("tx_count",    tx_count,    txq.size());
    check("rx_count",    rx_count,    rxq.size());
    check("tx_empty",    tx_empty,    txq.size() == 0);
    check("tx_full",     tx_full,     txq.size() == DEPTH);
    check("rx_empty",    rx_empty,    rxq.size() == 0);
    check("rx_full",     rx_full,     rxq.size() == DEPTH);
    check("tx_ovf",      tx_ovf,      ovf_m);
    check("rx_udf",      rx_udf,      udf_m);
    check("host_rdata",  host_rdata,  rd_exp);
  endtask

  initial begin
    int peak;
    int n;
    nreset = 1'b0; host_wdata = 8'h00; host_we = 0; host_re = 0; flush = 0; clear_flags = 0;
    rx_data_reg = 8'h00; spi_auto = 0; loopback = 0; frame_len = 6; spi_byte = 8'h00;
    reset_model();

    // Reset values
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_tx_empty", tx_empty, 1); check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_count", tx_count, 0); check("rst_rx_count", rx_count, 0);
    check("rst_tx_we", tx_reg_we, 0);   check("rst_rx_re", rx_reg_re, 0);
    check("rst_tx_data", tx_data_reg, 8'h00); check("rst_rdata", host_rdata, 8'h00);
    check("rst_flags", {tx_ovf, rx_udf, tx_full, rx_full}, 4'b0000);
    #2 nreset = 1'b1;
    step();

    // Two-byte burst paced by tx_reg_empty
    spi_auto = 1; loopback = 0; frame_len = 6;
    host_we = 1; host_wdata = 8'hA5; step();
    host_wdata = 8'h3C; step();
    host_we = 0;
    check("first_load_data", tx_data_reg, 8'hA5);
    check("first_load_we", tx_reg_we, 1);
    repeat (30) step();

    // Loopback of 0x01..0x05
    loopback = 1;
    host_we = 1;
    for (int i = 1; i <= 5; i++) begin host_wdata = 8'(i); step(); end
    host_we = 0;
    peak = 0;
    for (int i = 0; i < 80; i++) begin step(); if (int'(rx_count) > peak) peak = int'(rx_count); end
    check("rx_peak", peak, 5);
    host_re = 1;
    repeat (5) step();
    step();
    host_re = 0;
    check("udf_set", rx_udf, 1);
    check("udf_rdata_hold", host_rdata, 8'h05);
    clear_flags = 1; step(); clear_flags = 0;
    check("udf_cleared", rx_udf, 0);

    // Fill TX past full while spi_master is busy
    spi_auto = 0; frame_cnt = 0; tx_reg_empty = 1'b0;
    host_we = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin host_wdata = 8'($urandom); step(); end
    host_we = 0;
    check("fill_count", tx_count, DEPTH); check("fill_full", tx_full, 1); check("fill_ovf", tx_ovf, 1);
    clear_flags = 1; step(); clear_flags = 0;
    check("ovf_cleared", tx_ovf, 0);

    // Drain TX through loopback until RX fills
    spi_auto = 1; loopback = 1; tx_reg_empty = 1'b1; frame_len = 6;
    repeat (250) step();
    check("drain_tx_empty", tx_empty, 1);
    check("drain_rx_full", rx_full, 1);

    // RX full with a byte pending: held until the host makes room
    loopback = 0; rx_data_reg = 8'h77; rx_data_ready = 1'b1;
    repeat (5) step();
    check("rxfull_no_re", rx_reg_re, 0);
    host_re = 1; step(); host_re = 0;
    repeat (4) step();
    check("rxfull_refill", rx_count, DEPTH);

    // Same-cycle push and pop at count 8
    host_re = 1; repeat (8) step(); host_re = 0;
    repeat (3) step();
    check("rx_at_8", rx_count, 8);
    rx_data_reg = 8'($urandom); rx_data_ready = 1'b1; host_re = 1;
    step();
    host_re = 0;
    check("pushpop_count", rx_count, 8);
    repeat (3) step();

    // Randomized traffic with flushes and flag clears
    loopback = 1;
    for (int i = 0; i < 400; i++) begin
      host_we     = ($urandom_range(0, 1) == 1);
      host_wdata  = 8'($urandom);
      host_re     = ($urandom_range(0, 9) < 4);
      flush       = ($urandom_range(0, 39) == 0);
      clear_flags = ($urandom_range(0, 19) == 0);
      frame_len   = int'($urandom_range(3, 8));
      step();
    end
    host_we = 0; flush = 0; clear_flags = 0; host_re = 1; frame_len = 6;
    repeat (250) step();
    host_re = 0;
    check("random_tx_drained", tx_empty, 1);

    // Reset while the TX engine is in LOAD
    host_wdata = 8'h5A; host_we = 1; step(); host_we = 0;
    n = 0;
    while (tx_reg_we !== 1'b1 && n < 10) begin step(); n++; end
    check("load_reached", tx_reg_we, 1);
    host_we = 1; host_wdata = 8'hC3;
    #2 nreset = 1'b0;
    #1;
    host_we = 0;
    check("arst_tx_we", tx_reg_we, 0); check("arst_tx_count", tx_count, 0);
    check("arst_rx_count", rx_count, 0); check("arst_tx_empty", tx_empty, 1);
    check("arst_tx_data", tx_data_reg, 8'h00); check("arst_rdata", host_rdata, 8'h00);
    reset_model();
    @(negedge sysclk);
    nreset = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
